// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step decoder.
// Transition codes, FSM states, error counter ceiling, Gray decode.
package quad_pkg;

  typedef enum logic [1:0] {
    NONE,
    INC,
    DEC,
    ILLEGAL
  } trans_t;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam logic [3:0] ERR_CNT_MAX = 4'd15;

  // Position of {a,b} in the forward cycle 00,01,11,10.
  function automatic logic [1:0] gray_idx(
    input logic [1:0] ab
  );
    gray_idx = {ab[1], ab[1] ^ ab[0]};
  endfunction

  // A step of +1 is forward, -1 reverse, 2 means both bits moved.
  function automatic trans_t decode(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    logic [1:0] d;
    d = gray_idx(cur) - gray_idx(prev);
    unique case (d)
      2'd0:    decode = NONE;
      2'd1:    decode = INC;
      2'd2:    decode = ILLEGAL;
      default: decode = DEC;
    endcase
  endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// One encoder channel: synchronizer chain plus a stability filter.
// Ports: clk, reset, d (async in), load (track s directly), f (filtered).
module sync_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic load,
  output logic f
);

  logic [SYNC_STAGES-1:0] sr;
  logic [3:0]             cnt;
  logic                   s;

  assign s = sr[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
      f   <= 1'b0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], d};
      if (load) begin
        f   <= s;
        cnt <= '0;
      end else if (s == f) begin
        cnt <= '0;
      end else if (cnt == 4'(FILTER_LEN - 1)) begin
        f   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: filtered a/b to step/up pulses, errors counted.
// Ports: clk, reset, a, b in; step, up, err, err_cnt[3:0], ready out.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  output logic       step,
  output logic       up,
  output logic       err,
  output logic [3:0] err_cnt,
  output logic       ready
);

  localparam int INIT_LEN = SYNC_STAGES + FILTER_LEN;

  state_t     state;
  logic [4:0] icnt;
  logic [1:0] prev;
  logic       fa;
  logic       fb;
  logic       load;
  trans_t     tr;

  assign load = (state == INIT);

  sync_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_fa (
    .clk  (clk),
    .reset(reset),
    .d    (a),
    .load (load),
    .f    (fa)
  );

  sync_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_fb (
    .clk  (clk),
    .reset(reset),
    .d    (b),
    .load (load),
    .f    (fb)
  );

  always_comb begin
    tr = decode(prev, {fa, fb});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= INIT;
      icnt    <= '0;
      prev    <= '0;
      step    <= 1'b0;
      up      <= 1'b1;
      err     <= 1'b0;
      err_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      prev <= {fa, fb};
      unique case (state)
        INIT: begin
          if (icnt == 5'(INIT_LEN - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            icnt <= icnt + 5'd1;
          end
        end
        RUN: begin
          unique case (tr)
            INC: begin
              step <= 1'b1;
              up   <= 1'b1;
            end
            DEC: begin
              step <= 1'b1;
              up   <= 1'b0;
            end
            ILLEGAL: begin
              err <= 1'b1;
              if (err_cnt != ERR_CNT_MAX)
                err_cnt <= err_cnt + 4'd1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with default parameters.
// Drives encoder patterns and checks pulses, timing and error count.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       a;
  logic       b;
  logic       step;
  logic       up;
  logic       err;
  logic [3:0] err_cnt;
  logic       ready;

  int checks = 0;
  int errors = 0;
  logic [3:0] ctr = 4'd0;

  quad_step_decoder dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .step   (step),
    .up     (up),
    .err    (err),
    .err_cnt(err_cnt),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Apply {na,nb}, hold 10 cycles, expect pulses at cycle 6.
  task automatic drive(
    input logic  na,
    input logic  nb,
    input int    es,
    input int    ee,
    input logic  eu,
    input string tag
  );
    int   sc;
    int   ec;
    int   sat;
    int   eat;
    logic su;
    sc  = 0;
    ec  = 0;
    sat = 0;
    eat = 0;
    su  = up;
    a   = na;
    b   = nb;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step) begin
        sc++;
        sat = i;
        su  = up;
        ctr = up ? ctr + 4'd1 : ctr - 4'd1;
      end
      if (err) begin
        ec++;
        eat = i;
      end
      if (step && err) sc = 99;
    end
    chk($sformatf("%s_nstep", tag), sc, es);
    chk($sformatf("%s_nerr", tag), ec, ee);
    if (es == 1) begin
      chk($sformatf("%s_slat", tag), sat, 6);
      chk($sformatf("%s_up", tag), {31'd0, su}, {31'd0, eu});
    end
    if (ee == 1) begin
      chk($sformatf("%s_elat", tag), eat, 6);
      chk($sformatf("%s_uphold", tag), {31'd0, up}, {31'd0, eu});
    end
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    a     = 1'b0;
    b     = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_step", {31'd0, step}, 0);
    chk("rst_up", {31'd0, up}, 1);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_errcnt", {28'd0, err_cnt}, 0);
    chk("rst_ready", {31'd0, ready}, 0);

    reset = 1'b0;
    bad   = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (step || err) bad++;
      if (i == 4) chk("init_ready4", {31'd0, ready}, 0);
      if (i == 5) chk("init_ready5", {31'd0, ready}, 1);
    end
    chk("init_quiet", bad, 0);

    ctr = 4'd0;
    drive(1'b0, 1'b1, 1, 0, 1'b1, "fwd1");
    drive(1'b1, 1'b1, 1, 0, 1'b1, "fwd2");
    drive(1'b1, 1'b0, 1, 0, 1'b1, "fwd3");
    drive(1'b0, 1'b0, 1, 0, 1'b1, "fwd4");
    chk("fwd_ctr", {28'd0, ctr}, 4);

    ctr = 4'd0;
    drive(1'b1, 1'b0, 1, 0, 1'b0, "rev1");
    chk("rev_ctr1", {28'd0, ctr}, 4'hF);
    drive(1'b1, 1'b1, 1, 0, 1'b0, "rev2");
    drive(1'b0, 1'b1, 1, 0, 1'b0, "rev3");
    drive(1'b0, 1'b0, 1, 0, 1'b0, "rev4");
    chk("rev_ctr", {28'd0, ctr}, 4'hC);

    drive(1'b0, 1'b1, 1, 0, 1'b1, "pre_glitch");
    a = 1'b1;
    tick();
    tick();
    a   = 1'b0;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step || err) bad++;
    end
    chk("glitch_quiet", bad, 0);
    chk("glitch_f", {31'd0, dut.u_fa.f}, 0);
    drive(1'b1, 1'b1, 1, 0, 1'b1, "glitch_hold");

    drive(1'b0, 1'b0, 0, 1, 1'b1, "ill1");
    chk("ill1_cnt", {28'd0, err_cnt}, 1);
    for (int k = 2; k <= 20; k++) begin
      if (k[0]) drive(1'b0, 1'b0, 0, 1, 1'b1, $sformatf("ill%0d", k));
      else      drive(1'b1, 1'b1, 0, 1, 1'b1, $sformatf("ill%0d", k));
      if (k == 14) chk("ill14_cnt", {28'd0, err_cnt}, 14);
      if (k == 15) chk("ill15_cnt", {28'd0, err_cnt}, 15);
    end
    chk("ill_sat", {28'd0, err_cnt}, 15);

    a = 1'b1;
    b = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_step", {31'd0, step}, 0);
    chk("mid_err", {31'd0, err}, 0);
    chk("mid_errcnt", {28'd0, err_cnt}, 0);
    chk("mid_ready", {31'd0, ready}, 0);
    chk("mid_up", {31'd0, up}, 1);
    tick();
    tick();
    reset = 1'b0;
    bad   = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (step || err) bad++;
      if (i == 5) chk("re_ready", {31'd0, ready}, 1);
    end
    chk("re_quiet", bad, 0);
    chk("re_fa", {31'd0, dut.u_fa.f}, 1);
    chk("re_fb", {31'd0, dut.u_fb.f}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
